sprite_compositor: RTL and testbench

Parametrised pixel compositor between the VGA timing generator and the RGB pins. It overlays NUM_SPRITES hardware sprites on a background colour stream, with fixed per-index priority and a colour-key transparency value. It also provides frame-rate-divided animation of sprite-sheet ROMs and per-frame sticky collision flags between sprite 0 (the player) and every other sprite. It is a 3-stage registered pipeline: hs/vs/valid are delayed to stay aligned with the pixel data.

---
 rtl/sprite_compositor_if.sv | 26 ++
 rtl/sprite_compositor.sv | 132 +++++++++++++
 tb/tb_sprite_compositor.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_compositor_if.sv
// rtl/sprite_compositor_if.sv - pixel stream in (timing + background) and composited stream out
interface sprite_compositor_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           pix_valid;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           hs_in;
  logic           vs_in;
  logic [11:0]    bg_rgb;
  logic [11:0]    rgb;
  logic           rgb_valid;
  logic           hs_out;
  logic           vs_out;

  modport master (
    output pix_valid, x, y, hs_in, vs_in, bg_rgb,
    input  rgb, rgb_valid, hs_out, vs_out
  );

  modport slave (
    input  pix_valid, x, y, hs_in, vs_in, bg_rgb,
    output rgb, rgb_valid, hs_out, vs_out
  );
endinterface

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - 3-stage sprite overlay pipeline with animation and player collision flags
module sprite_compositor #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPR_W       = 16,
  parameter int          SPR_H       = 16,
  parameter int          FRAMES      = 4,
  parameter int          ANIM_DIV    = 8,
  parameter int          X_W         = 10,
  parameter int          Y_W         = 10,
  parameter logic [11:0] KEY         = 12'h00f,
  localparam int         ADDR_W      = $clog2(SPR_W * SPR_H * FRAMES),
  localparam int         FR_W        = $clog2(FRAMES)
) (
  input  logic                               clk,
  input  logic                               clrn,
  sprite_compositor_if.slave                 pix,
  input  logic                               frame_start,
  input  logic [NUM_SPRITES-1:0]             spr_en,
  input  logic [NUM_SPRITES-1:0]             spr_anim,
  input  logic [NUM_SPRITES*(X_W+Y_W)-1:0]   spr_pos,
  output logic [NUM_SPRITES*ADDR_W-1:0]      rom_addr,
  input  logic [NUM_SPRITES*12-1:0]          rom_data,
  output logic [NUM_SPRITES-1:0]             collide,
  output logic [FR_W-1:0]                    anim_frame
);
  localparam int               DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
  localparam logic [X_W:0]     RX_LIM   = (X_W + 1)'(SPR_W);
  localparam logic [Y_W:0]     RY_LIM   = (Y_W + 1)'(SPR_H);

  logic [X_W-1:0]            x1_q;
  logic [Y_W-1:0]            y1_q;
  logic                      v1_q, hs1_q, vs1_q;
  logic [11:0]               bg1_q;
  logic [NUM_SPRITES*12-1:0] rom2_q;
  logic [11:0]               bg2_q;
  logic                      v2_q, hs2_q, vs2_q;
  logic [NUM_SPRITES-1:0]    win2_q;
  logic [11:0]               rgb3_q, rgb3_d;
  logic                      v3_q, hs3_q, vs3_q;
  logic [DIV_W-1:0]          div_q, div_d, div_step;
  logic [FR_W-1:0]           anim_q, anim_d;
  logic [NUM_SPRITES-1:0]    coll_q, coll_d, collide_q, collide_d;
  logic [NUM_SPRITES-1:0]    in_win, opaque, hits;
  logic [11:0]               sel;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    logic [X_W-1:0]  sx;
    logic [Y_W-1:0]  sy;
    logic [X_W:0]    rx;
    logic [Y_W:0]    ry;
    logic [FR_W-1:0] fi;

    assign sx = spr_pos[g*(X_W+Y_W) +: X_W];
    assign sy = spr_pos[g*(X_W+Y_W)+X_W +: Y_W];
    // The extra top bit is the borrow, so sprites never wrap past the screen edge.
    assign rx = {1'b0, x1_q} - {1'b0, sx};
    assign ry = {1'b0, y1_q} - {1'b0, sy};
    assign in_win[g] = ~rx[X_W] & ~ry[Y_W] & (rx < RX_LIM) & (ry < RY_LIM);
    assign fi = spr_anim[g] ? anim_q : '0;
    assign rom_addr[g*ADDR_W +: ADDR_W] =
      ADDR_W'(32'(ry) * SPR_W * FRAMES + 32'(fi) * SPR_W + 32'(rx));
    assign opaque[g] = win2_q[g] & (rom2_q[g*12 +: 12] != KEY);
  end

  assign hits = opaque & {NUM_SPRITES{opaque[0]}} & ~NUM_SPRITES'(1);

  always_comb begin
    sel = bg2_q;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) sel = rom2_q[i*12 +: 12];
    end
    rgb3_d = v2_q ? sel : 12'h000;
  end

  // The frame steps on the pulse that brings div_cnt to its last value (every pulse when ANIM_DIV is 1).
  always_comb begin
    div_d    = div_q;
    anim_d   = anim_q;
    div_step = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    if (frame_start) begin
      div_d = div_step;
      if (div_step == DIV_LAST) anim_d = anim_q + FR_W'(1);
    end
  end

  always_comb begin
    coll_d    = coll_q | hits;
    collide_d = collide_q;
    if (frame_start) begin
      collide_d = coll_q | hits;
      coll_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      x1_q <= '0; y1_q <= '0; v1_q <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0; bg1_q <= '0;
      rom2_q <= '0; bg2_q <= '0; v2_q <= 1'b0; hs2_q <= 1'b0; vs2_q <= 1'b0; win2_q <= '0;
      rgb3_q <= '0; v3_q <= 1'b0; hs3_q <= 1'b0; vs3_q <= 1'b0;
      div_q <= '0; anim_q <= '0; coll_q <= '0; collide_q <= '0;
    end else begin
      x1_q      <= pix.x;
      y1_q      <= pix.y;
      v1_q      <= pix.pix_valid;
      hs1_q     <= pix.hs_in;
      vs1_q     <= pix.vs_in;
      bg1_q     <= pix.bg_rgb;
      rom2_q    <= rom_data;
      bg2_q     <= bg1_q;
      v2_q      <= v1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      win2_q    <= spr_en & in_win & {NUM_SPRITES{v1_q}};
      rgb3_q    <= rgb3_d;
      v3_q      <= v2_q;
      hs3_q     <= hs2_q;
      vs3_q     <= vs2_q;
      div_q     <= div_d;
      anim_q    <= anim_d;
      coll_q    <= coll_d;
      collide_q <= collide_d;
    end
  end

  assign pix.rgb       = rgb3_q;
  assign pix.rgb_valid = v3_q;
  assign pix.hs_out    = hs3_q;
  assign pix.vs_out    = vs3_q;
  assign collide       = collide_q;
  assign anim_frame    = anim_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed bench with a pixel-level reference model for sprite_compositor
module tb_sprite_compositor;
  localparam int          NS   = 4;
  localparam int          XW   = 10;
  localparam int          YW   = 10;
  localparam int          SW   = 16;
  localparam int          SH   = 16;
  localparam int          FR   = 4;
  localparam int          AD   = 2;
  localparam int          AW   = 10;
  localparam logic [11:0] KEYC = 12'h00f;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  sprite_compositor_if #(.X_W(XW), .Y_W(YW)) pif ();

  logic                 frame_start = 1'b0;
  logic [NS-1:0]        spr_en = '0;
  logic [NS-1:0]        spr_anim = '0;
  logic [NS*(XW+YW)-1:0] spr_pos = '0;
  logic [NS*AW-1:0]     rom_addr;
  logic [NS*12-1:0]     rom_data;
  logic [NS-1:0]        collide;
  logic [1:0]           anim_frame;

  sprite_compositor #(
    .NUM_SPRITES(NS), .SPR_W(SW), .SPR_H(SH), .FRAMES(FR), .ANIM_DIV(AD),
    .X_W(XW), .Y_W(YW), .KEY(KEYC)
  ) dut (
    .clk(clk), .clrn(clrn), .pix(pif), .frame_start(frame_start),
    .spr_en(spr_en), .spr_anim(spr_anim), .spr_pos(spr_pos),
    .rom_addr(rom_addr), .rom_data(rom_data), .collide(collide), .anim_frame(anim_frame)
  );

  // Sprite-sheet contents: 0 green, 1 red with a keyed first column, 2 red, 3 encodes its address.
  function automatic logic [11:0] rom_fn(input int s, input int addr);
    if (s == 0) return 12'h0f0;
    if (s == 1) return (addr % SW == 0) ? KEYC : 12'hf00;
    if (s == 2) return 12'hf00;
    return 12'h800 | 12'(addr);
  endfunction

  always_comb begin
    rom_data = '0;
    for (int s = 0; s < NS; s++) rom_data[s*12 +: 12] = rom_fn(s, int'(rom_addr[s*AW +: AW]));
  end

  typedef struct packed {
    logic [11:0]   rgb;
    logic          v;
    logic          hs;
    logic          vs;
    logic [NS-1:0] hits;
  } exp_t;

  function automatic int frame_of(input int p);
    return ((p + AD - 1) / AD) % FR;
  endfunction

  function automatic exp_t model(input int px, input int py, input logic pv, input logic hs,
                                 input logic vs, input logic [11:0] bg, input int frame);
    exp_t r;
    logic [NS-1:0] op;
    logic found;
    logic [11:0] col, c;
    int sx, sy, rx, ry;
    r = '0; op = '0; found = 1'b0; col = bg;
    for (int s = 0; s < NS; s++) begin
      sx = int'(spr_pos[s*(XW+YW) +: XW]);
      sy = int'(spr_pos[s*(XW+YW)+XW +: YW]);
      rx = px - sx;
      ry = py - sy;
      if (spr_en[s] && pv && rx >= 0 && rx < SW && ry >= 0 && ry < SH) begin
        c = rom_fn(s, ry*SW*FR + (spr_anim[s] ? frame : 0)*SW + rx);
        if (c != KEYC) begin
          op[s] = 1'b1;
          if (!found) begin col = c; found = 1'b1; end
        end
      end
    end
    r.rgb  = pv ? col : 12'h000;
    r.v    = pv;
    r.hs   = hs;
    r.vs   = vs;
    r.hits = op[0] ? {op[NS-1:1], 1'b0} : '0;
    return r;
  endfunction

  exp_t          e1 = '0, e2 = '0, e3 = '0;
  int            pulses = 0;
  logic [NS-1:0] m_acc = '0, m_coll = '0;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e1 <= '0; e2 <= '0; e3 <= '0; pulses <= 0; m_acc <= '0; m_coll <= '0;
    end else begin
      e1 <= model(int'(pif.x), int'(pif.y), pif.pix_valid, pif.hs_in, pif.vs_in, pif.bg_rgb,
                  frame_of(pulses + int'(frame_start)));
      e2 <= e1;
      e3 <= e2;
      if (frame_start) begin
        pulses <= pulses + 1;
        m_coll <= m_acc | e2.hits;
        m_acc  <= '0;
      end else begin
        m_acc <= m_acc | e2.hits;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic cmp_cycle();
    checks++;
    if ({pif.rgb, pif.rgb_valid, pif.hs_out, pif.vs_out, collide, anim_frame} !==
        {e3.rgb, e3.v, e3.hs, e3.vs, m_coll, 2'(frame_of(pulses))}) begin
      errors++;
      $display("FAIL pipe at %0t got rgb=%h v=%b hs=%b vs=%b coll=%b fr=%0d want rgb=%h v=%b hs=%b vs=%b coll=%b fr=%0d",
               $time, pif.rgb, pif.rgb_valid, pif.hs_out, pif.vs_out, collide, anim_frame,
               e3.rgb, e3.v, e3.hs, e3.vs, m_coll, frame_of(pulses));
    end
  endtask

  task automatic drive(input int px, input int py, input logic pv, input logic [11:0] bg,
                       input logic hs, input logic vs);
    pif.x = XW'(px); pif.y = YW'(py); pif.pix_valid = pv;
    pif.bg_rgb = bg; pif.hs_in = hs; pif.vs_in = vs;
  endtask

  task automatic idle();
    drive(0, 0, 1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic probe(input string name, input int px, input int py, input logic pv,
                       input logic [11:0] want);
    drive(px, py, pv, 12'h123, px[0], py[0]);
    @(negedge clk) idle();
    @(negedge clk);
    @(negedge clk);
    chk(name, 32'(pif.rgb), 32'(want));
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic set_pos(input int s, input int sx, input int sy);
    spr_pos[s*(XW+YW) +: XW+YW] = {YW'(sy), XW'(sx)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int seq[8];
    seq = '{1, 1, 2, 2, 3, 3, 0, 0};
    idle();
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    fork
      forever begin
        @(negedge clk);
        cmp_cycle();
      end
    join_none
    chk("reset_rgb", 32'(pif.rgb), 0);
    chk("reset_valid", 32'(pif.rgb_valid), 0);
    chk("reset_anim", 32'(anim_frame), 0);
    chk("reset_collide", 32'(collide), 0);

    for (int i = 0; i < 8; i++) begin
      drive(i, 0, 1'b1, 12'h123, i[0], i[1]);
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);
    probe("bg_pass", 10, 10, 1'b1, 12'h123);

    set_pos(1, 40, 100);
    spr_en = 4'b0010;
    probe("win_x39", 39, 100, 1'b1, 12'h123);
    probe("win_key", 40, 100, 1'b1, 12'h123);
    probe("win_x41", 41, 100, 1'b1, 12'hf00);
    probe("win_corner", 55, 115, 1'b1, 12'hf00);
    probe("win_x56", 56, 100, 1'b1, 12'h123);
    probe("win_y116", 41, 116, 1'b1, 12'h123);
    probe("win_blank", 45, 105, 1'b0, 12'h000);
    for (int yy = 98; yy < 118; yy += 3) begin
      for (int xx = 36; xx < 60; xx++) begin
        drive(xx, yy, 1'b1, 12'(xx * 7 + yy), xx == 36, yy == 98);
        @(negedge clk);
      end
    end
    idle();
    repeat (4) @(negedge clk);

    set_pos(0, 200, 200);
    set_pos(2, 200, 200);
    spr_en = 4'b0101;
    probe("prio_both", 205, 205, 1'b1, 12'h0f0);
    spr_en = 4'b0100;
    probe("prio_s2", 205, 205, 1'b1, 12'hf00);
    set_pos(2, 1020, 10);
    probe("edge_1023", 1023, 12, 1'b1, 12'hf00);
    probe("edge_nowrap", 0, 12, 1'b1, 12'h123);

    spr_en = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      pulse();
      chk($sformatf("anim_seq%0d", k), 32'(anim_frame), 32'(seq[k]));
    end
    repeat (3) pulse();
    chk("anim_at_2", 32'(anim_frame), 2);

    set_pos(3, 100, 50);
    spr_en = 4'b1000;
    spr_anim = 4'b1000;
    drive(103, 52, 1'b1, 12'h123, 1'b0, 1'b0);
    @(negedge clk) idle();
    chk("addr_anim", 32'(rom_addr[3*AW +: AW]), 163);
    repeat (3) @(negedge clk);
    probe("rgb_anim", 103, 52, 1'b1, 12'h8a3);
    spr_anim = 4'b0000;
    drive(103, 52, 1'b1, 12'h123, 1'b0, 1'b0);
    @(negedge clk) idle();
    chk("addr_static", 32'(rom_addr[3*AW +: AW]), 131);
    repeat (3) @(negedge clk);
    probe("rgb_static", 103, 52, 1'b1, 12'h883);

    set_pos(0, 300, 300);
    set_pos(3, 305, 305);
    spr_en = 4'b1001;
    probe("coll_pix", 306, 306, 1'b1, 12'h0f0);
    pulse();
    chk("coll_set", 32'(collide), 32'h8);
    probe("nocoll_pix", 301, 301, 1'b1, 12'h0f0);
    pulse();
    chk("coll_clear", 32'(collide), 0);
    drive(306, 306, 1'b1, 12'h123, 1'b0, 1'b0);
    @(negedge clk) idle();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    chk("coll_coincident", 32'(collide), 32'h8);
    chk("anim_before_reset", 32'(anim_frame), 3);

    for (int i = 0; i < 4; i++) begin
      drive(400 + i, 20, 1'b1, 12'h5a5, 1'b1, 1'b1);
      @(negedge clk);
    end
    #2 clrn = 1'b0;
    #1;
    chk("rst_rgb", 32'(pif.rgb), 0);
    chk("rst_valid", 32'(pif.rgb_valid), 0);
    chk("rst_sync", 32'({pif.hs_out, pif.vs_out}), 0);
    chk("rst_collide", 32'(collide), 0);
    chk("rst_anim", 32'(anim_frame), 0);
    idle();
    @(negedge clk);
    clrn = 1'b1;
    spr_en = 4'b0000;
    probe("after_reset", 10, 10, 1'b1, 12'h123);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
